// File: rtl/gauri_piso_tx_32b.sv
// Parallel-to-serial transmitter: takes a word over valid/ready and shifts it out
// one bit per clock, with a matching bit index and one-hot bit-select for the decoder side.
module gauri_piso_tx_32b #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] pdata,
  input  logic             ser_hold,
  output logic             ser_out,
  output logic             ser_en,
  output logic             ser_last,
  output logic [IDX_W-1:0] bit_idx,
  output logic [WIDTH-1:0] bit_sel,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_POS  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? LAST_POS : '0;
  localparam logic [IDX_W-1:0] FINAL_IDX = MSB_FIRST ? '0 : LAST_POS;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic in_shift;
  logic advance;
  logic at_final;
  logic accept;

  assign in_shift = (state_q == SHIFT);
  assign advance  = in_shift && !ser_hold;
  assign at_final = in_shift && (idx_q == FINAL_IDX);
  assign ld_ready = !rst && (!in_shift || (at_final && !ser_hold));
  assign accept   = ld_valid && ld_ready;

  // The bit on the line is always the outgoing end of the shifter; zero fill
  // leaves the register empty once the word has gone out.
  assign ser_out  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign ser_en   = advance;
  assign ser_last = at_final;
  assign bit_idx  = idx_q;
  assign bit_sel  = advance ? (WIDTH'(1) << idx_q) : '0;
  assign busy     = in_shift;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the datapath registers are reset too because
  // the reset values of ser_out and bit_idx are visible on the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;

    if (accept) begin
      state_d = SHIFT;
      shreg_d = pdata;
      idx_d   = FIRST_IDX;
    end else if (advance) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      if (at_final) begin
        // Counter parks on the final index; only a new load moves it back.
        state_d = IDLE;
      end else begin
        idx_d = MSB_FIRST ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
      end
    end
  end

endmodule
